instr_fetch_unit: RTL and testbench

//   Sits directly downstream of the program counter. Latches the current PC,

---
 rtl/instr_fetch_unit.sv | 139 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Latches the PC, fetches one 32-bit instruction over a req/ack handshake of
//   arbitrary latency and holds it for decode until it is consumed. pc_hold
//   feeds the PC's no_update input, so the PC advances only when the held
//   instruction retires.
//
// Ports
//   clk          in   posedge clock
//   reset        in   asynchronous, active-high reset
//   pc_addr      in   [31:0] current PC
//   consume      in   decode accepts instr (only meaningful in HOLD)
//   flush        in   redirect: drop in-flight fetch, held instr and fault
//   imem_req     out  fetch request
//   imem_addr    out  [31:0] fetch address, stable while imem_req is high
//   imem_ack     in   memory response valid
//   imem_rdata   in   [31:0] instruction word, valid with imem_ack
//   imem_err     in   bus error, qualified by imem_ack
//   instr        out  [31:0] held instruction
//   instr_valid  out  instr holds a fetched, unconsumed instruction
//   fetch_fault  out  sticky fault (misaligned PC, bus error, timeout)
//   pc_hold      out  low only in the cycle the held instr retires
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] NOP     = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_addr,
    input  logic        consume,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fetch_fault,
    output logic        pc_hold
);

    localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;

    state_t        state, state_n;
    logic          req_n, valid_n, fault_n;
    logic [31:0]   addr_n, instr_n;
    logic [CW-1:0] cnt, cnt_n;

    // Flush wins over retirement so a redirect never lets the PC step.
    assign pc_hold = flush | ~((state == HOLD) & consume);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr       <= NOP;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_n;
            imem_req    <= req_n;
            imem_addr   <= addr_n;
            instr       <= instr_n;
            instr_valid <= valid_n;
            fetch_fault <= fault_n;
            cnt         <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        req_n   = imem_req;
        addr_n  = imem_addr;
        instr_n = instr;
        valid_n = instr_valid;
        fault_n = fetch_fault;
        cnt_n   = cnt;

        if (flush) begin
            // A same-cycle ack is dropped; the memory tolerates the abandoned request.
            state_n = IDLE;
            req_n   = 1'b0;
            instr_n = NOP;
            valid_n = 1'b0;
            fault_n = 1'b0;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pc_addr[1:0] != 2'b00) begin
                        state_n = FAULT;
                        fault_n = 1'b1;
                    end else begin
                        state_n = REQ;
                        addr_n  = pc_addr;
                        req_n   = 1'b1;
                        cnt_n   = '0;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        req_n = 1'b0;
                        if (imem_err) begin
                            state_n = FAULT;
                            fault_n = 1'b1;
                        end else begin
                            state_n = HOLD;
                            instr_n = imem_rdata;
                            valid_n = 1'b1;
                        end
                    end else if (cnt == CNT_LAST) begin
                        // Counter saturates here, so it never wraps.
                        state_n = FAULT;
                        req_n   = 1'b0;
                        fault_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (consume) begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                    end
                end
                FAULT: ; // sticky until flush or reset
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a random
// run, every cycle compared against a transaction-level reference model.
module tb_instr_fetch_unit;

    localparam int          TO  = 255;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_addr;
    logic        consume, flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic [31:0] instr;
    logic        instr_valid, fetch_fault, pc_hold;

    always #5 clk = ~clk;

    instr_fetch_unit #(.TIMEOUT(TO), .NOP(NOP)) dut (
        .clk(clk), .reset(reset), .pc_addr(pc_addr), .consume(consume),
        .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .instr(instr), .instr_valid(instr_valid), .fetch_fault(fetch_fault),
        .pc_hold(pc_hold)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the fetch unit described by what is outstanding
    // (a request, a held word, a fault) rather than by a state code.
    logic        m_req, m_valid, m_fault;
    logic [31:0] m_addr, m_instr;
    int          m_wait;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req = 0; m_valid = 0; m_fault = 0; m_addr = 0; m_instr = NOP; m_wait = 0;
    endtask

    function automatic logic m_hold(input logic cons, input logic fl);
        return fl ? 1'b1 : !(m_valid && cons);
    endfunction

    // One clock edge of the specified behaviour, from the currently driven inputs.
    task automatic model_step();
        if (flush) begin
            m_req = 0; m_valid = 0; m_instr = NOP; m_fault = 0; m_wait = 0;
        end else if (m_fault) begin
            // nothing moves until flush
        end else if (m_valid) begin
            if (consume) m_valid = 0;
        end else if (m_req) begin
            if (imem_ack) begin
                m_req = 0;
                if (imem_err) m_fault = 1;
                else begin m_instr = imem_rdata; m_valid = 1; end
            end else if (m_wait == TO - 1) begin
                m_req = 0; m_fault = 1;
            end else m_wait++;
        end else begin
            if (pc_addr[1:0] != 2'b00) m_fault = 1;
            else begin m_addr = pc_addr; m_req = 1; m_wait = 0; end
        end
    endtask

    task automatic cmp_all();
        chk("imem_req",    imem_req,    m_req);
        chk("imem_addr",   imem_addr,   m_addr);
        chk("instr",       instr,       m_instr);
        chk("instr_valid", instr_valid, m_valid);
        chk("fetch_fault", fetch_fault, m_fault);
    endtask

    // Drive one cycle of inputs, check the combinational hold, clock, compare.
    task automatic cyc(input logic [31:0] pc, input logic cons, input logic fl,
                       input logic ack, input logic err, input logic [31:0] rd);
        pc_addr = pc; consume = cons; flush = fl;
        imem_ack = ack; imem_err = err; imem_rdata = rd;
        #1;
        chk("pc_hold", pc_hold, m_hold(cons, fl));
        @(posedge clk);
        model_step();
        #1;
        cmp_all();
    endtask

    initial begin
        logic [31:0] pc, rd;
        logic        c, f, a, e, h;

        reset = 1; pc_addr = 0; consume = 0; flush = 0;
        imem_ack = 0; imem_err = 0; imem_rdata = 0;
        model_reset();
        #1;
        chk("rst_req",   imem_req,    0);
        chk("rst_addr",  imem_addr,   0);
        chk("rst_instr", instr,       NOP);
        chk("rst_valid", instr_valid, 0);
        chk("rst_fault", fetch_fault, 0);
        chk("rst_hold",  pc_hold,     1);
        #11 reset = 0;

        // 1: first fetch, ack in the same cycle as req
        cyc(0, 0, 0, 0, 0, 0);
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 0);
        cyc(0, 0, 0, 1, 0, 32'h0050_0093);
        chk("t1_instr", instr, 32'h0050_0093);
        chk("t1_valid", instr_valid, 1);

        // 3: hold for 4 cycles, then consume; next fetch from 4
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk("t3_instr", instr, 32'h0050_0093);
            chk("t3_hold", pc_hold, 1);
        end
        pc_addr = 0; consume = 1; #1;
        chk("t3_hold_low", pc_hold, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("t3_valid", instr_valid, 0);
        cyc(4, 0, 0, 0, 0, 0);
        chk("t3_addr", imem_addr, 4);

        // 2: ack arrives after 5 waiting cycles
        for (int i = 0; i < 5; i++) begin
            cyc(4, 0, 0, 0, 0, 0);
            chk("t2_req", imem_req, 1);
            chk("t2_addr", imem_addr, 4);
            chk("t2_valid", instr_valid, 0);
        end
        cyc(4, 0, 0, 1, 0, 32'h1234_5678);
        chk("t2_instr", instr, 32'h1234_5678);
        cyc(4, 1, 0, 0, 0, 0);

        // 4: misaligned PC faults without a request; sticky; flush clears
        cyc(6, 0, 0, 0, 0, 0);
        chk("t4_fault", fetch_fault, 1);
        chk("t4_req", imem_req, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(8, 1, 0, 1, 0, 0);
            chk("t4_sticky", fetch_fault, 1);
        end
        cyc(8, 0, 1, 0, 0, 0);
        chk("t4_clr", fetch_fault, 0);
        cyc(8, 0, 0, 0, 0, 0);
        chk("t4_restart", imem_addr, 8);

        // 5a: bus error
        cyc(8, 0, 0, 1, 1, 32'hFFFF_FFFF);
        chk("t5_err", fetch_fault, 1);
        cyc(8, 0, 1, 0, 0, 0);
        // 5b: timeout fires on exactly the 255th waiting cycle
        cyc(32'hC, 0, 0, 0, 0, 0);
        for (int n = 1; n <= TO; n++) begin
            cyc(32'hC, 0, 0, 0, 0, 0);
            if (n == TO - 1 || n == TO) begin
                chk("t5_to_fault", fetch_fault, (n == TO) ? 1 : 0);
                chk("t5_to_req",   imem_req,    (n == TO) ? 0 : 1);
            end
        end
        cyc(32'hC, 0, 1, 0, 0, 0);

        // 6: flush beats a same-cycle ack; async reset mid-request
        cyc(32'h10, 0, 0, 0, 0, 0);
        cyc(32'h10, 0, 1, 1, 0, 32'hDEAD_BEEF);
        chk("t6_instr", instr, NOP);
        chk("t6_valid", instr_valid, 0);
        cyc(32'h10, 0, 0, 0, 0, 0);
        chk("t6_req_up", imem_req, 1);
        #2 reset = 1;
        #1;
        chk("t6_async", imem_req, 0);
        model_reset();
        #2 reset = 0;

        // Random run: bench acts as PC and memory
        pc = 32'h100;
        for (int i = 0; i < 3000; i++) begin
            c  = ($urandom_range(1, 0) == 1);
            f  = ($urandom_range(29, 0) == 0) || (m_fault && $urandom_range(3, 0) == 0);
            a  = ($urandom_range(2, 0) == 0);
            e  = ($urandom_range(19, 0) == 0);
            rd = $urandom;
            if (f) pc = {$urandom_range(4095, 0), 2'b00};
            else if ($urandom_range(59, 0) == 0) pc = pc | 32'd2;
            h = m_hold(c, f);
            cyc(pc, c, f, a, e, rd);
            if (!h) pc = pc + 4;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
